// File: rtl/vmicro16_apb_pkg.sv
// Shared types and defaults for the vmicro16 APB round-robin arbiter.
package vmicro16_apb_pkg;

  localparam int APB_WIDTH       = 16;
  localparam int SEL_LSB_DEFAULT = 12;
  localparam logic [APB_WIDTH-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_t;

  // One-hot decode of the 4-bit slave index field.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/vmicro16_rr_pick.sv
// Combinational round-robin priority encoder: first requester after the
// last grant, wrapping around, wins.
module vmicro16_rr_pick
  import vmicro16_apb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] idx,
  output logic          valid
);

  logic [GW-1:0] cand_s;
  logic          hit_s;

  // Walk the candidates last+1 .. last+N; only the first hit is latched in.
  always_comb begin
    idx    = last;
    valid  = 1'b0;
    cand_s = last;
    hit_s  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s = GW'((int'(last) + k) % N);
      hit_s  = req[cand_s] & ~valid;
      idx    = hit_s ? cand_s : idx;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/vmicro16_apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB peripheral bus between several cores,
// with address decode and a watchdog that aborts stalled transfers.
module vmicro16_apb_rr_arbiter
  import vmicro16_apb_pkg::*;
#(
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 8,
  parameter int BUS_WIDTH    = APB_WIDTH,
  parameter int SEL_LSB      = SEL_LSB_DEFAULT,
  parameter int TIMEOUT      = 255,
  parameter logic [BUS_WIDTH-1:0] ERR_DATA = ERR_DATA_DEFAULT,
  localparam int GW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  output logic [GW-1:0]                     grant,
  output logic                              bus_err
);

  localparam int          MW        = MASTER_PORTS * BUS_WIDTH;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  apb_state_t             state_r, state_s;
  logic [GW-1:0]          grant_r, grant_s;
  logic [GW-1:0]          pick_idx_s;
  logic                   pick_valid_s;
  logic [BUS_WIDTH-1:0]   req_addr_s, req_wdata_s;
  logic                   req_write_s;
  logic [3:0]             sel_idx_s;
  logic [15:0]            sel_onehot_s;
  logic                   unmapped_s;
  logic [BUS_WIDTH-1:0]   paddr_r, paddr_s;
  logic [BUS_WIDTH-1:0]   pwdata_r, pwdata_s;
  logic                   pwrite_r, pwrite_s;
  logic [SLAVE_PORTS-1:0] psel_r, psel_s;
  logic                   penable_r, penable_s;
  logic [MW-1:0]          prdata_r, prdata_s;
  logic [MASTER_PORTS-1:0] pready_r, pready_s;
  logic                   bus_err_r, bus_err_s;
  logic [15:0]            wdog_r, wdog_s;
  logic                   unused_s;

  vmicro16_rr_pick #(
    .N  (MASTER_PORTS),
    .GW (GW)
  ) u_pick (
    .req   (S_PSELx),
    .last  (grant_r),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  // Mux out the winning master's request and decode its slave index.
  always_comb begin
    req_addr_s   = S_PADDR[int'(pick_idx_s)*BUS_WIDTH +: BUS_WIDTH];
    req_wdata_s  = S_PWDATA[int'(pick_idx_s)*BUS_WIDTH +: BUS_WIDTH];
    req_write_s  = S_PWRITE[pick_idx_s];
    sel_idx_s    = req_addr_s[SEL_LSB +: 4];
    sel_onehot_s = onehot16(sel_idx_s);
    unmapped_s   = ({1'b0, sel_idx_s} >= 5'(SLAVE_PORTS));
  end

  // Next-state and next-output logic; DONE outputs are loaded on entry.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    paddr_s   = paddr_r;
    pwdata_s  = pwdata_r;
    pwrite_s  = pwrite_r;
    psel_s    = psel_r;
    penable_s = penable_r;
    prdata_s  = prdata_r;
    wdog_s    = wdog_r;
    pready_s  = '0;
    bus_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_s  = pick_idx_s;
          paddr_s  = req_addr_s;
          pwdata_s = req_wdata_s;
          pwrite_s = req_write_s;
          if (unmapped_s) begin
            state_s              = ST_DONE;
            pready_s[pick_idx_s] = 1'b1;
            prdata_s[int'(pick_idx_s)*BUS_WIDTH +: BUS_WIDTH] = ERR_DATA;
            bus_err_s            = 1'b1;
          end else begin
            state_s = ST_SETUP;
            psel_s  = sel_onehot_s[SLAVE_PORTS-1:0];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s   = ST_ACCESS;
        penable_s = 1'b1;
        wdog_s    = 16'd0;
      end
      ST_ACCESS: begin
        if (M_PREADY) begin
          state_s           = ST_DONE;
          psel_s            = '0;
          penable_s         = 1'b0;
          pready_s[grant_r] = 1'b1;
          prdata_s[int'(grant_r)*BUS_WIDTH +: BUS_WIDTH] = M_PRDATA;
        end else if (wdog_r == WDOG_LAST) begin
          // Slave is dead: release the bus and hand the core an error word.
          state_s           = ST_DONE;
          psel_s            = '0;
          penable_s         = 1'b0;
          pready_s[grant_r] = 1'b1;
          prdata_s[int'(grant_r)*BUS_WIDTH +: BUS_WIDTH] = ERR_DATA;
          bus_err_s         = 1'b1;
        end else begin
          wdog_s = wdog_r + 16'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        psel_s    = '0;
        penable_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      grant_r   <= GW'(MASTER_PORTS - 1);
      paddr_r   <= '0;
      pwdata_r  <= '0;
      pwrite_r  <= 1'b0;
      psel_r    <= '0;
      penable_r <= 1'b0;
      prdata_r  <= '0;
      pready_r  <= '0;
      bus_err_r <= 1'b0;
      wdog_r    <= 16'd0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      paddr_r   <= paddr_s;
      pwdata_r  <= pwdata_s;
      pwrite_r  <= pwrite_s;
      psel_r    <= psel_s;
      penable_r <= penable_s;
      prdata_r  <= prdata_s;
      pready_r  <= pready_s;
      bus_err_r <= bus_err_s;
      wdog_r    <= wdog_s;
    end
  end

  assign M_PADDR   = paddr_r;
  assign M_PWDATA  = pwdata_r;
  assign M_PWRITE  = pwrite_r;
  assign M_PSELx   = psel_r;
  assign M_PENABLE = penable_r;
  assign S_PRDATA  = prdata_r;
  assign S_PREADY  = pready_r;
  assign bus_err   = bus_err_r;
  assign grant     = grant_r;

  // PENABLE from the cores carries no arbitration meaning.
  assign unused_s = ^{S_PENABLE, sel_onehot_s};

endmodule

// File: tb/tb_vmicro16_apb_rr_arbiter.sv
// Randomized bench for the APB round-robin arbiter against a
// transaction-level reference model.
module tb_vmicro16_apb_rr_arbiter;

  localparam int MP = 4;
  localparam int SP = 8;
  localparam int BW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   s_paddr, s_pwdata, s_prdata;
  logic [3:0]    s_pwrite, s_psel, s_penable, s_pready;
  logic [15:0]   m_paddr, m_pwdata, m_prdata;
  logic          m_pwrite, m_penable, m_pready, bus_err;
  logic [7:0]    m_psel;
  logic [1:0]    grant;

  int            checks = 0;
  int            errors = 0;
  int            last_g;
  logic [15:0]   exp_prd [MP];
  int            g;

  vmicro16_apb_rr_arbiter #(
    .MASTER_PORTS (MP),
    .SLAVE_PORTS  (SP),
    .BUS_WIDTH    (BW),
    .SEL_LSB      (12),
    .TIMEOUT      (TO),
    .ERR_DATA     (16'hDEAD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (s_paddr),
    .S_PWRITE  (s_pwrite),
    .S_PSELx   (s_psel),
    .S_PENABLE (s_penable),
    .S_PWDATA  (s_pwdata),
    .S_PRDATA  (s_prdata),
    .S_PREADY  (s_pready),
    .M_PADDR   (m_paddr),
    .M_PWRITE  (m_pwrite),
    .M_PSELx   (m_psel),
    .M_PENABLE (m_penable),
    .M_PWDATA  (m_pwdata),
    .M_PRDATA  (m_prdata),
    .M_PREADY  (m_pready),
    .grant     (grant),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rotation rule: nearest requester strictly after the last grant.
  function automatic int next_grant(input logic [3:0] req, input int last);
    next_grant = -1;
    for (int k = MP; k >= 1; k--) begin
      if (((req >> ((last + k) % MP)) & 4'd1) != 4'd0) next_grant = (last + k) % MP;
    end
  endfunction

  function automatic logic [63:0] packed_prd();
    for (int j = 0; j < MP; j++) packed_prd[j*16 +: 16] = exp_prd[j];
  endfunction

  function automatic int rand_wait();
    case ($urandom_range(0, 9))
      0, 1:    rand_wait = 0;
      2:       rand_wait = 1;
      3:       rand_wait = 2;
      4:       rand_wait = 3;
      5:       rand_wait = TO - 1;
      6:       rand_wait = TO;
      7:       rand_wait = 30;
      default: rand_wait = 0;
    endcase
  endfunction

  task automatic add_requests(input int skip);
    for (int j = 0; j < MP; j++) begin
      if (j != skip && s_psel[j] == 1'b0 && $urandom_range(0, 1) == 1) begin
        s_paddr[j*16 +: 16]  = {4'($urandom_range(0, 9)), 12'($urandom)};
        s_pwdata[j*16 +: 16] = 16'($urandom);
        s_pwrite[j]          = 1'($urandom);
        s_psel[j]            = 1'b1;
      end
    end
    s_penable = s_psel;
  endtask

  // One whole transaction, entered at the negedge of the IDLE cycle that
  // samples the requests; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input int wait_n, input logic [15:0] sdata,
                        input bit rnd, output int g_out);
    int          gg, sidx, acc;
    bit          unm, err;
    logic [15:0] a, wd;
    logic        w;
    gg    = next_grant(s_psel, last_g);
    g_out = gg;
    if (gg < 0) return;
    a    = s_paddr[gg*16 +: 16];
    wd   = s_pwdata[gg*16 +: 16];
    w    = s_pwrite[gg];
    sidx = int'(a[15:12]);
    unm  = (sidx >= SP);
    acc  = (wait_n + 1 > TO) ? TO : wait_n + 1;
    err  = unm || (wait_n + 1 > TO);
    @(negedge clk);
    check("grant", 64'(grant), 64'(gg));
    check("m_paddr", 64'(m_paddr), 64'(a));
    check("m_pwdata", 64'(m_pwdata), 64'(wd));
    check("m_pwrite", 64'(m_pwrite), 64'(w));
    if (unm) begin
      check("unmapped_psel", 64'(m_psel), 64'd0);
      check("unmapped_pready", 64'(s_pready), 64'd1 << gg);
    end else begin
      check("setup_psel", 64'(m_psel), 64'd1 << sidx);
      check("setup_penable", 64'(m_penable), 64'd0);
      check("setup_pready", 64'(s_pready), 64'd0);
      m_pready = 1'($urandom);
      if (rnd && $urandom_range(0, 7) == 0) begin
        s_psel[gg]    = 1'b0;
        s_penable[gg] = 1'b0;
      end
      for (int i = 1; i <= acc; i++) begin
        @(negedge clk);
        check("access_penable", 64'(m_penable), 64'd1);
        check("access_psel", 64'(m_psel), 64'd1 << sidx);
        check("access_paddr", 64'(m_paddr), 64'(a));
        check("access_pwdata", 64'(m_pwdata), 64'(wd));
        check("access_pready", 64'(s_pready), 64'd0);
        check("access_bus_err", 64'(bus_err), 64'd0);
        m_pready = (i == wait_n + 1);
        m_prdata = m_pready ? sdata : 16'($urandom);
      end
      @(negedge clk);
      check("done_pready", 64'(s_pready), 64'd1 << gg);
      check("done_psel", 64'(m_psel), 64'd0);
      check("done_penable", 64'(m_penable), 64'd0);
    end
    exp_prd[gg] = err ? 16'hDEAD : sdata;
    last_g      = gg;
    check("done_prdata", s_prdata, packed_prd());
    check("done_bus_err", 64'(bus_err), 64'(err));
    s_psel[gg]    = 1'b0;
    s_penable[gg] = 1'b0;
    m_pready      = 1'($urandom);
    m_prdata      = 16'($urandom);
    if (rnd) add_requests(gg);
    @(negedge clk);
    check("idle_pready", 64'(s_pready), 64'd0);
    check("idle_bus_err", 64'(bus_err), 64'd0);
    check("idle_psel", 64'(m_psel), 64'd0);
    check("idle_prdata", s_prdata, packed_prd());
  endtask

  task automatic set_master(input int j, input logic [15:0] a,
                            input logic [15:0] wd, input logic w);
    s_paddr[j*16 +: 16]  = a;
    s_pwdata[j*16 +: 16] = wd;
    s_pwrite[j]          = w;
    s_psel[j]            = 1'b1;
    s_penable            = s_psel;
  endtask

  task automatic model_reset();
    last_g = MP - 1;
    for (int j = 0; j < MP; j++) exp_prd[j] = 16'd0;
  endtask

  initial begin
    reset     = 1'b1;
    s_paddr   = 64'd0;
    s_pwdata  = 64'd0;
    s_pwrite  = 4'd0;
    s_psel    = 4'd0;
    s_penable = 4'd0;
    m_prdata  = 16'd0;
    m_pready  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_psel", 64'(m_psel), 64'd0);
    check("rst_penable", 64'(m_penable), 64'd0);
    check("rst_paddr", 64'(m_paddr), 64'd0);
    check("rst_pready", 64'(s_pready), 64'd0);
    check("rst_prdata", s_prdata, 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_grant", 64'(grant), 64'd3);
    reset = 1'b0;

    // single read from master 0, slave 1, zero wait
    set_master(0, 16'h1004, 16'h0000, 1'b0);
    do_txn(0, 16'h1234, 1'b0, g);

    // all four write to slave 0 at once
    for (int j = 0; j < MP; j++) set_master(j, 16'(j * 4), 16'hA000 + 16'(j), 1'b1);
    for (int j = 0; j < MP; j++) do_txn(0, 16'($urandom), 1'b0, g);

    // three wait states
    set_master(1, 16'h3010, 16'h0000, 1'b0);
    do_txn(3, 16'h5A5A, 1'b0, g);

    // dead slave, watchdog boundary on both sides
    set_master(2, 16'h2000, 16'h0000, 1'b0);
    do_txn(100, 16'h1111, 1'b0, g);
    set_master(0, 16'h4002, 16'h0000, 1'b0);
    do_txn(TO - 1, 16'h7777, 1'b0, g);
    set_master(3, 16'h6002, 16'h0000, 1'b0);
    do_txn(TO, 16'h8888, 1'b0, g);

    // unmapped slave
    set_master(3, 16'hF000, 16'h0000, 1'b0);
    do_txn(0, 16'h2222, 1'b0, g);

    // reset during ACCESS
    set_master(2, 16'h5008, 16'h0000, 1'b0);
    m_pready = 1'b0;
    @(negedge clk);
    check("rst_mid_setup_psel", 64'(m_psel), 64'd1 << 5);
    m_pready = 1'b0;
    @(negedge clk);
    check("rst_mid_access_penable", 64'(m_penable), 64'd1);
    reset = 1'b1;
    set_master(0, 16'h1000, 16'h0000, 1'b0);
    @(negedge clk);
    check("rst_mid_psel", 64'(m_psel), 64'd0);
    check("rst_mid_penable", 64'(m_penable), 64'd0);
    check("rst_mid_pready", 64'(s_pready), 64'd0);
    check("rst_mid_prdata", s_prdata, 64'd0);
    check("rst_mid_grant", 64'(grant), 64'd3);
    reset = 1'b0;
    model_reset();
    do_txn(0, 16'h0BEE, 1'b0, g);
    check("rst_first_winner", 64'(g), 64'd0);
    do_txn(1, 16'h0CAF, 1'b0, g);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      while (s_psel == 4'd0) add_requests(-1);
      do_txn(rand_wait(), 16'($urandom), 1'b1, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
